// File: rtl/pipe_ctrl.sv
// Pipeline control for a five-stage pipe.
// Turns hazard, branch, memory-stall and halt requests into per-register
// write enables, FD flush and DX bubble strobes. Also keeps two saturating
// statistics counters: stall cycles, and flush cycles spent squashing fetches.
module pipe_ctrl #(
  parameter int CTRL_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_nop,
  input  logic             branch_or_jump,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             halt_in,
  output logic             pc_we,
  output logic             fd_we,
  output logic             dx_we,
  output logic             xm_we,
  output logic             mw_we,
  output logic             fd_flush,
  output logic             dx_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, CTRL, HALT} state_t;

  localparam logic [2:0] LAT = 3'(CTRL_LAT);

  state_t     state, state_nxt;
  logic [2:0] ctrl_left, ctrl_left_nxt;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             en);
    if (en && (c != {CNT_W{1'b1}})) return c + CNT_W'(1);
    return c;
  endfunction

  // State register and squash countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      ctrl_left <= 3'd0;
    end else begin
      state     <= state_nxt;
      ctrl_left <= ctrl_left_nxt;
    end
  end

  // Next-state and output decode, highest-priority request first.
  always_comb begin
    pc_we         = 1'b1;
    fd_we         = 1'b1;
    dx_we         = 1'b1;
    xm_we         = 1'b1;
    mw_we         = 1'b1;
    fd_flush      = 1'b0;
    dx_bubble     = 1'b0;
    halted        = 1'b0;
    state_nxt     = state;
    ctrl_left_nxt = ctrl_left;
    if (rst) begin
      // Hold every register and present NOPs while reset is asserted.
      {pc_we, fd_we, dx_we, xm_we, mw_we} = 5'b00000;
      fd_flush  = 1'b1;
      dx_bubble = 1'b1;
    end else if (state == HALT) begin
      {pc_we, fd_we, dx_we, xm_we, mw_we} = 5'b00000;
      halted = 1'b1;
    end else if (dmem_stall) begin
      // Whole pipe frozen; state and countdown hold.
      {pc_we, fd_we, dx_we, xm_we, mw_we} = 5'b00000;
    end else if (halt_in) begin
      // Let the HALT retire through MW, freeze everything upstream.
      {pc_we, fd_we, dx_we, xm_we} = 4'b0000;
      state_nxt = HALT;
    end else if (state == CTRL) begin
      // Squash window: fetched words are replaced by NOPs; hazard and
      // branch requests cannot come from squashed slots.
      fd_flush      = 1'b1;
      pc_we         = ~imem_stall;
      ctrl_left_nxt = ctrl_left - 3'd1;
      if (ctrl_left <= 3'd1) begin
        state_nxt     = RUN;
        ctrl_left_nxt = 3'd0;
      end
    end else if (hazard_nop) begin
      pc_we     = 1'b0;
      fd_we     = 1'b0;
      dx_bubble = 1'b1;
    end else if (branch_or_jump) begin
      state_nxt     = CTRL;
      ctrl_left_nxt = LAT;
    end else if (imem_stall) begin
      pc_we    = 1'b0;
      fd_flush = 1'b1;
    end
  end

  // Statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, (state != HALT) && !pc_we);
      flush_cnt <= sat_inc(flush_cnt, (state == CTRL) && fd_flush);
    end
  end

endmodule
